laser_multi_cover: RTL and testbench

// Parametrised successor to the two-circle LASER coverage engine. Loads NPTS grid points, then places

---
 rtl/laser_pkg.sv | 34 +++
 rtl/laser_multi_cover_if.sv | 19 +
 rtl/laser_hit_counter.sv | 22 ++
 rtl/laser_multi_cover.sv | 145 ++++++++++++++
 tb/tb_laser_multi_cover.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_pkg.sv
// Shared types and the squared-distance test for the multi-circle coverage engine.
package laser_pkg;

  localparam int unsigned PW  = 4;
  localparam int unsigned PR2 = 16;

  typedef struct packed {
    logic [PW-1:0] x;
    logic [PW-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    LOAD,
    SCAN,
    UPDATE,
    FINISH
  } state_t;

  // dx/dy are signed PW+1 bits; squares and sum carried in 2*PW+2 bits, no grid wrap
  function automatic logic in_circle(point_t p, point_t c, int unsigned r2 = PR2);
    logic signed [PW:0]     dx;
    logic signed [PW:0]     dy;
    logic signed [2*PW+1:0] ex;
    logic signed [2*PW+1:0] ey;
    logic signed [2*PW+1:0] sq;
    dx = $signed({1'b0, p.x}) - $signed({1'b0, c.x});
    dy = $signed({1'b0, p.y}) - $signed({1'b0, c.y});
    ex = {{(PW+1){dx[PW]}}, dx};
    ey = {{(PW+1){dy[PW]}}, dy};
    sq = ex * ex + ey * ey;
    return $unsigned(sq) <= (2*PW+2)'(r2);
  endfunction

endpackage

// File: rtl/laser_multi_cover_if.sv
// Point stream in, placement result out.
interface laser_multi_cover_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned NPTS  = 40,
  parameter int unsigned NCIRC = 2
);
  localparam int unsigned CNTW = $clog2(NPTS + 1);

  logic              IN_VALID;
  logic [W-1:0]      X;
  logic [W-1:0]      Y;
  logic [NCIRC*W-1:0] C_X;
  logic [NCIRC*W-1:0] C_Y;
  logic [CNTW-1:0]   COVER;
  logic              DONE;

  modport master (output IN_VALID, X, Y, input C_X, C_Y, COVER, DONE);
  modport slave  (input IN_VALID, X, Y, output C_X, C_Y, COVER, DONE);
endinterface

// File: rtl/laser_hit_counter.sv
// Counts points inside a candidate circle that are not already claimed by another circle.
module laser_hit_counter
  import laser_pkg::*;
#(
  parameter int unsigned NPTS = 40,
  parameter int unsigned R2   = PR2,
  localparam int unsigned CNTW = $clog2(NPTS + 1)
) (
  input  point_t            center,
  input  point_t            pts [NPTS],
  input  logic [NPTS-1:0]   mask,
  output logic [CNTW-1:0]   hits_c
);

  always_comb begin
    hits_c = '0;
    for (int i = 0; i < NPTS; i++) begin
      if (in_circle(pts[i], center, R2) && !mask[i]) hits_c = hits_c + CNTW'(1);
    end
  end

endmodule

// File: rtl/laser_multi_cover.sv
// Loads NPTS points, then places NCIRC circles by repeated exhaustive per-circle re-placement.
// W must equal laser_pkg::PW since point_t is sized by the package.
module laser_multi_cover
  import laser_pkg::*;
#(
  parameter int unsigned W        = PW,
  parameter int unsigned NPTS     = 40,
  parameter int unsigned NCIRC    = 2,
  parameter int unsigned R2       = PR2,
  parameter int unsigned MAX_PASS = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  laser_multi_cover_if.slave bus
);

  localparam int unsigned CNTW  = $clog2(NPTS + 1);
  localparam int unsigned KW    = (NCIRC > 1) ? $clog2(NCIRC) : 1;
  localparam int unsigned PASSW = $clog2(MAX_PASS + 1);
  localparam int unsigned CANDW = 2 * W;

  state_t           state;
  point_t           pts [NPTS];
  logic [CNTW-1:0]  cnt;
  point_t           pos [NCIRC];
  logic [NCIRC-1:0] placed;
  logic [KW-1:0]    k;
  logic [PASSW-1:0] pass;
  logic             changed;
  logic [CANDW-1:0] cand;
  point_t           best;
  logic [CNTW-1:0]  best_gain;

  point_t           cand_pt_c;
  logic [NPTS-1:0]  cov_c;
  logic [NPTS-1:0]  mask_c;
  logic [NPTS-1:0]  union_c;
  logic [CNTW-1:0]  cover_c;
  logic [CNTW-1:0]  gain_c;
  logic             chg_c;

  // Coverage of each placed circle: others mask the gain, all of them form COVER
  always_comb begin
    cand_pt_c = point_t'{x: PW'(cand[W-1:0]), y: PW'(cand[CANDW-1:W])};
    mask_c    = '0;
    union_c   = '0;
    cov_c     = '0;
    for (int j = 0; j < NCIRC; j++) begin
      for (int i = 0; i < NPTS; i++) begin
        cov_c[i] = placed[j] && in_circle(pts[i], pos[j], R2);
      end
      union_c = union_c | cov_c;
      if (KW'(j) != k) mask_c = mask_c | cov_c;
    end
    cover_c = '0;
    for (int i = 0; i < NPTS; i++) cover_c = cover_c + CNTW'(union_c[i]);
    chg_c = changed || !placed[k] || (pos[k] != best);
  end

  laser_hit_counter #(.NPTS(NPTS), .R2(R2)) u_gain (
    .center (cand_pt_c),
    .pts    (pts),
    .mask   (mask_c),
    .hits_c (gain_c)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= LOAD;
      cnt       <= '0;
      placed    <= '0;
      k         <= '0;
      pass      <= '0;
      changed   <= 1'b0;
      cand      <= '0;
      best      <= '0;
      best_gain <= '0;
      for (int i = 0; i < NPTS; i++) pts[i] <= '0;
      for (int j = 0; j < NCIRC; j++) pos[j] <= '0;
      bus.C_X   <= '0;
      bus.C_Y   <= '0;
      bus.COVER <= '0;
      bus.DONE  <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      case (state)
        LOAD: begin
          if (bus.IN_VALID) begin
            pts[cnt] <= point_t'{x: PW'(bus.X), y: PW'(bus.Y)};
            if (cnt == CNTW'(NPTS - 1)) begin
              state   <= SCAN;
              cnt     <= '0;
              k       <= '0;
              pass    <= '0;
              changed <= 1'b0;
              cand    <= '0;
              placed  <= '0;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        // First candidate seeds best; later ones need a strictly larger gain
        SCAN: begin
          if (cand == '0 || gain_c > best_gain) begin
            best      <= cand_pt_c;
            best_gain <= gain_c;
          end
          cand <= cand + CANDW'(1);
          if (cand == '1) state <= UPDATE;
        end
        UPDATE: begin
          pos[k]    <= best;
          placed[k] <= 1'b1;
          if (k == KW'(NCIRC - 1)) begin
            k    <= '0;
            pass <= pass + PASSW'(1);
            if (!chg_c || pass == PASSW'(MAX_PASS - 1)) begin
              state <= FINISH;
            end else begin
              changed <= 1'b0;
              state   <= SCAN;
            end
          end else begin
            k       <= k + KW'(1);
            changed <= chg_c;
            state   <= SCAN;
          end
        end
        FINISH: begin
          for (int j = 0; j < NCIRC; j++) begin
            bus.C_X[j*W +: W] <= W'(pos[j].x);
            bus.C_Y[j*W +: W] <= W'(pos[j].y);
          end
          bus.COVER <= cover_c;
          bus.DONE  <= 1'b1;
          cnt       <= '0;
          state     <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_multi_cover.sv
// Bench for laser_multi_cover: directed cluster jobs plus random jobs against a behavioural placement model.
module tb_laser_multi_cover;

  localparam int unsigned W    = 4;
  localparam int unsigned NPTS = 40;
  localparam int          GRID = 16;
  localparam int          SCAN_CYC = GRID * GRID + 1;
  localparam int          BOUND = 20000;

  logic CLK = 1'b0;
  logic RST_N;

  int n_checks = 0;
  int n_errs   = 0;
  int mx [NPTS];
  int my [NPTS];
  int exp_cx [3];
  int exp_cy [3];
  int exp_cover;
  int exp_pass;
  int lat;

  laser_multi_cover_if #(.W(W), .NPTS(NPTS), .NCIRC(2)) bus0 ();
  laser_multi_cover_if #(.W(W), .NPTS(NPTS), .NCIRC(3)) bus1 ();

  laser_multi_cover #(.W(W), .NPTS(NPTS), .NCIRC(2), .R2(16), .MAX_PASS(8)) u_dut0 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus0)
  );

  laser_multi_cover #(.W(W), .NPTS(NPTS), .NCIRC(3), .R2(16), .MAX_PASS(1)) u_dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input int x, input int y);
    if (sel == 0) begin
      bus0.IN_VALID = v; bus0.X = 4'(x); bus0.Y = 4'(y);
    end else begin
      bus1.IN_VALID = v; bus1.X = 4'(x); bus1.Y = 4'(y);
    end
  endtask

  function automatic int get_done(input int sel);
    return (sel == 0) ? int'(bus0.DONE) : int'(bus1.DONE);
  endfunction

  function automatic int get_cover(input int sel);
    return (sel == 0) ? int'(bus0.COVER) : int'(bus1.COVER);
  endfunction

  function automatic int get_cx(input int sel, input int j);
    return (sel == 0) ? int'(bus0.C_X[j*W +: W]) : int'(bus1.C_X[j*W +: W]);
  endfunction

  function automatic int get_cy(input int sel, input int j);
    return (sel == 0) ? int'(bus0.C_Y[j*W +: W]) : int'(bus1.C_Y[j*W +: W]);
  endfunction

  function automatic bit hit(input int px, input int py, input int cx, input int cy);
    return ((px - cx) * (px - cx) + (py - cy) * (py - cy)) <= 16;
  endfunction

  task automatic fill(input int x0, input int y0, input int n0,
                      input int x1, input int y1, input int n1,
                      input int x2, input int y2);
    for (int i = 0; i < NPTS; i++) begin
      if (i < n0)           begin mx[i] = x0; my[i] = y0; end
      else if (i < n0 + n1) begin mx[i] = x1; my[i] = y1; end
      else                  begin mx[i] = x2; my[i] = y2; end
    end
  endtask

  // Greedy re-placement straight from the placement rules
  task automatic model(input int ncirc, input int maxpass);
    bit pl [3];
    bit changed, other;
    int best, bx, by, g;
    for (int j = 0; j < 3; j++) begin pl[j] = 0; exp_cx[j] = 0; exp_cy[j] = 0; end
    exp_pass = 0;
    do begin
      changed = 0;
      for (int k = 0; k < ncirc; k++) begin
        best = -1; bx = 0; by = 0;
        for (int y = 0; y < GRID; y++) begin
          for (int x = 0; x < GRID; x++) begin
            g = 0;
            for (int i = 0; i < NPTS; i++) begin
              other = 0;
              for (int j = 0; j < ncirc; j++)
                if (j != k && pl[j] && hit(mx[i], my[i], exp_cx[j], exp_cy[j])) other = 1;
              if (hit(mx[i], my[i], x, y) && !other) g++;
            end
            if (g > best) begin best = g; bx = x; by = y; end
          end
        end
        if (!pl[k] || bx != exp_cx[k] || by != exp_cy[k]) changed = 1;
        exp_cx[k] = bx; exp_cy[k] = by; pl[k] = 1;
      end
      exp_pass++;
    end while (changed && exp_pass < maxpass);
    exp_cover = 0;
    for (int i = 0; i < NPTS; i++) begin
      other = 0;
      for (int j = 0; j < ncirc; j++) if (hit(mx[i], my[i], exp_cx[j], exp_cy[j])) other = 1;
      if (other) exp_cover++;
    end
  endtask

  task automatic run_job(input string name, input int sel, input bit bubbles, input bit junk,
                         output int n);
    int ncirc, maxpass;
    ncirc   = (sel == 0) ? 2 : 3;
    maxpass = (sel == 0) ? 8 : 1;
    model(ncirc, maxpass);
    for (int i = 0; i < NPTS; i++) begin
      if (bubbles) begin
        while ($urandom_range(1, 0) == 1) begin
          drive(sel, 1'b0, $urandom_range(15, 0), $urandom_range(15, 0));
          @(posedge CLK); #1;
        end
      end
      drive(sel, 1'b1, mx[i], my[i]);
      @(posedge CLK); #1;
    end
    drive(sel, 1'b0, 0, 0);
    n = 0;
    while (get_done(sel) == 0 && n < BOUND) begin
      if (junk) drive(sel, 1'($urandom_range(1, 0)), $urandom_range(15, 0), $urandom_range(15, 0));
      @(posedge CLK); #1;
      n++;
    end
    drive(sel, 1'b0, 0, 0);
    check({name, "_latency"}, n, exp_pass * ncirc * SCAN_CYC + 1);
    for (int j = 0; j < ncirc; j++) begin
      check($sformatf("%s_cx%0d", name, j), get_cx(sel, j), exp_cx[j]);
      check($sformatf("%s_cy%0d", name, j), get_cy(sel, j), exp_cy[j]);
    end
    check({name, "_cover"}, get_cover(sel), exp_cover);
    @(posedge CLK); #1;
    check({name, "_done_pulse"}, get_done(sel), 0);
    check({name, "_cover_hold"}, get_cover(sel), exp_cover);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    #12;
    check("rst_done0", get_done(0), 0);
    check("rst_cover0", get_cover(0), 0);
    check("rst_cx0", int'(bus0.C_X), 0);
    check("rst_cy0", int'(bus0.C_Y), 0);
    check("rst_done1", get_done(1), 0);
    check("rst_cover1", get_cover(1), 0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;

    // All points stacked at one spot: second circle has nothing left to gain
    fill(8, 8, 40, 0, 0, 0, 0, 0);
    run_job("stack", 0, 1'b0, 1'b0, lat);
    check("stack_c0x_k", get_cx(0, 0), 8);
    check("stack_c0y_k", get_cy(0, 0), 4);
    check("stack_c1x_k", get_cx(0, 1), 0);
    check("stack_c1y_k", get_cy(0, 1), 0);
    check("stack_cover_k", get_cover(0), 40);

    fill(2, 2, 20, 13, 13, 20, 0, 0);
    run_job("two", 0, 1'b0, 1'b0, lat);
    check("two_lat_k", lat, 2 * 2 * SCAN_CYC + 1);
    check("two_c0x_k", get_cx(0, 0), 0);
    check("two_c0y_k", get_cy(0, 0), 0);
    check("two_c1x_k", get_cx(0, 1), 13);
    check("two_c1y_k", get_cy(0, 1), 9);
    check("two_cover_k", get_cover(0), 40);

    run_job("bubbles", 0, 1'b1, 1'b1, lat);
    check("bubbles_c1y_k", get_cy(0, 1), 9);

    // Abort mid-scan: outputs clear asynchronously, next job is clean
    for (int i = 0; i < NPTS; i++) begin
      drive(0, 1'b1, mx[i], my[i]);
      @(posedge CLK); #1;
    end
    drive(0, 1'b0, 0, 0);
    repeat (100) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("abort_done", get_done(0), 0);
    check("abort_cx", int'(bus0.C_X), 0);
    check("abort_cy", int'(bus0.C_Y), 0);
    check("abort_cover", get_cover(0), 0);
    @(posedge CLK); #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    run_job("reload", 0, 1'b0, 1'b0, lat);
    check("reload_c1x_k", get_cx(0, 1), 13);

    // Single pass with three circles
    fill(2, 2, 13, 13, 2, 13, 8, 13);
    run_job("three", 1, 1'b0, 1'b1, lat);
    check("three_lat_k", lat, 3 * SCAN_CYC + 1);
    check("three_cover_k", get_cover(1), 40);

    // Back-to-back jobs on the same engine
    fill(15, 15, 40, 0, 0, 0, 0, 0);
    run_job("b2b1", 0, 1'b0, 1'b0, lat);
    check("b2b1_c0x_k", get_cx(0, 0), 15);
    check("b2b1_c0y_k", get_cy(0, 0), 11);
    fill(2, 2, 20, 13, 13, 20, 0, 0);
    run_job("b2b2", 0, 1'b0, 1'b0, lat);
    check("b2b2_c1y_k", get_cy(0, 1), 9);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NPTS; i++) begin
        mx[i] = $urandom_range(15, 0);
        my[i] = $urandom_range(15, 0);
      end
      run_job($sformatf("rnd%0d", r), 0, 1'b1, 1'b1, lat);
    end
    for (int i = 0; i < NPTS; i++) begin
      mx[i] = $urandom_range(15, 0);
      my[i] = $urandom_range(15, 0);
    end
    run_job("rnd3c", 1, 1'b1, 1'b1, lat);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
